backprop_sequencer: RTL
=======================

# backprop_sequencer

Sequential controller that drives the backprop stack controller's step inputs (`is_update`, `w_layer_index`, `w_row_index`, `is_cost_layer`, `backprop_cost`) through one complete backward pass. A pass visits every row of the cost layer first, then every row of each dense layer from the highest index down to 0. The block holds each step until the datapath acknowledges it, then signals completion with a one-cycle `done` pulse. It sits between the training top-level, which issues `start`, and the stack controller.

## Interface
Parameters:
- `size`, 3: rows per layer; must equal the stack controller's `size`.
- `layer_count`, 2: number of dense layers. The cost layer uses index `layer_count`; dense layers use `layer_count-1` down to 0.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a pass; sampled only in IDLE.
- `abort`  in  1  synchronous cancel of a pass in progress.
- `step_ack`  in  1  the datapath has consumed the current step.
- `is_update`  out  1  a step is presented.
- `backprop_cost`  out  1  current step is in the cost phase.
- `is_cost_layer`  out  1  current layer is the cost layer.
- `w_layer_index`  out  32  current layer index.
- `w_row_index`  out  32  current row index, range 0..size-1.
- `busy`  out  1  high in COST and DENSE.
- `done`  out  1  one-cycle pulse when a pass completes.
- `step_count`  out  32  number of steps acked in the current pass; cleared on `start`.

## Operation
- States: IDLE, COST, DENSE, DONE.
- IDLE: all outputs 0. `start`=1 moves to COST with layer=`layer_count`, row=0 and clears `step_count`.
- COST:
  - Outputs: `is_update`=1, `backprop_cost`=1, `is_cost_layer`=1, `w_layer_index`=`layer_count`.
  - On `step_ack`: row increments. At row `size-1`, row wraps to 0, layer becomes `layer_count-1`, state moves to DENSE.
- DENSE:
  - Outputs: `is_update`=1, `backprop_cost`=0, `is_cost_layer`=0.
  - On `step_ack` at row `size-1`: row goes to 0 and layer decrements.
  - On `step_ack` at layer 0, row `size-1`: state moves to DONE.
- DONE: `done`=1 and `is_update`=0 for one cycle, then IDLE unconditionally.
- `step_count` increments on every acked step and holds its final value through DONE and IDLE until the next `start`.
- `start` while busy: ignored.
- `abort` in COST or DENSE: moves to IDLE next edge with no `done` pulse. `abort` has priority over a simultaneous `step_ack`.
- `layer_count`=0: DENSE is skipped; COST row `size-1` acked goes directly to DONE.
- Index arithmetic is 32-bit unsigned. The layer decrement never wraps below 0 because the DENSE→DONE transition happens first.

## Timing
- Reset (`reset_n`=0, asynchronous): state IDLE. Every output is 0, including `step_count`.
- Latency, `start` to first step: `start` high at edge N gives `is_update`=1 after edge N.
- Step hold: the index outputs are registered and stay stable until an edge with `step_ack`=1. The next step's indices appear after that edge.
- `step_ack` held high continuously advances one step per cycle.
- Pass length with continuous ack: `size`*(`layer_count`+1) step cycles plus 1 DONE cycle.
- `done` is asserted in the cycle after the last acked step. `busy` is 0 in that cycle.
- `reset_n` asserted mid-pass: immediate return to IDLE with all outputs 0. No `done`.
- `step_ack` outside COST/DENSE: ignored.

## Structure
- Shared package `backprop_pkg`:
  - state enum `bp_seq_state_t` {IDLE, COST, DENSE, DONE}.
  - `INDEX_WIDTH`=32.
- Sub-module `layer_row_counter`:
  - Holds the row/layer pair.
  - Inputs: `load`, `load_layer`, `advance`.
  - Outputs: `row`, `layer`, `row_last` (row==`size-1`), `layer_zero`.
- The FSM and `step_count` stay in the top module.

## Test plan
Defaults `size`=3, `layer_count`=2.
- Reset: `reset_n` low mid-pass → all outputs 0 immediately; state IDLE after release.
- Full pass, `step_ack` held 1: (layer,row) sequence is (2,0)(2,1)(2,2)(1,0)(1,1)(1,2)(0,0)(0,1)(0,2).
  - `backprop_cost`/`is_cost_layer` are 1 for the first 3 steps only.
  - `done` pulses at cycle 10; `step_count`=9.
- Stalled ack: `step_ack` low for 4 cycles at (1,1) → outputs hold (1,1) with `is_update`=1; pass resumes on ack.
- Abort: `abort`=1 together with `step_ack` at (1,0) → IDLE next cycle, no `done`, `step_count`=3.
- `start` pulsed during DENSE → ignored, sequence unaffected. `start` in the same cycle as DONE → ignored. A `start` one cycle later begins a new pass at (2,0).
- `layer_count`=0 build: sequence (0,0)(0,1)(0,2), all with `backprop_cost`=1, then `done`; `step_count`=3.

Source files
------------

// File: rtl/backprop_pkg.sv
// rtl/backprop_pkg.sv - shared types and widths for the backprop pass sequencer
package backprop_pkg;

    localparam int INDEX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COST  = 2'd1,
        DENSE = 2'd2,
        DONE  = 2'd3
    } bp_seq_state_t;

endpackage

// File: rtl/layer_row_counter.sv
// rtl/layer_row_counter.sv - row/layer position register walked by the backprop sequencer
module layer_row_counter
    import backprop_pkg::*;
#(
    parameter int size = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load,
    input  logic [INDEX_WIDTH-1:0] load_layer,
    input  logic                   advance,
    output logic [INDEX_WIDTH-1:0] row,
    output logic [INDEX_WIDTH-1:0] layer,
    output logic                   row_last,
    output logic                   layer_zero
);

    localparam logic [INDEX_WIDTH-1:0] ROW_MAX = INDEX_WIDTH'(size - 1);

    logic [INDEX_WIDTH-1:0] row_q, row_d;
    logic [INDEX_WIDTH-1:0] layer_q, layer_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_q   <= '0;
            layer_q <= '0;
        end else begin
            row_q   <= row_d;
            layer_q <= layer_d;
        end
    end

    // The caller never advances from the last row of layer 0, so layer cannot underflow.
    always_comb begin
        row_d   = row_q;
        layer_d = layer_q;
        if (load) begin
            row_d   = '0;
            layer_d = load_layer;
        end else if (advance) begin
            if (row_q == ROW_MAX) begin
                row_d   = '0;
                layer_d = layer_q - 1'b1;
            end else begin
                row_d = row_q + 1'b1;
            end
        end
    end

    assign row        = row_q;
    assign layer      = layer_q;
    assign row_last   = (row_q == ROW_MAX);
    assign layer_zero = (layer_q == '0);

endmodule

// File: rtl/backprop_sequencer.sv
// rtl/backprop_sequencer.sv - steps the stack controller through one cost + dense backward pass
module backprop_sequencer
    import backprop_pkg::*;
#(
    parameter int size        = 3,
    parameter int layer_count = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   step_ack,
    output logic                   is_update,
    output logic                   backprop_cost,
    output logic                   is_cost_layer,
    output logic [INDEX_WIDTH-1:0] w_layer_index,
    output logic [INDEX_WIDTH-1:0] w_row_index,
    output logic                   busy,
    output logic                   done,
    output logic [INDEX_WIDTH-1:0] step_count
);

    bp_seq_state_t          state_q, state_d;
    logic [INDEX_WIDTH-1:0] step_count_q, step_count_d;
    logic [INDEX_WIDTH-1:0] row, layer;
    logic                   row_last, layer_zero;
    logic                   active, load, accept, final_step;

    assign active     = (state_q == COST) || (state_q == DENSE);
    assign load       = (state_q == IDLE) && start;
    assign accept     = active && step_ack && !abort;
    assign final_step = row_last && layer_zero;

    layer_row_counter #(.size(size)) u_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .load_layer (INDEX_WIDTH'(layer_count)),
        .advance    (accept && !final_step),
        .row        (row),
        .layer      (layer),
        .row_last   (row_last),
        .layer_zero (layer_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            step_count_q <= '0;
        end else begin
            state_q      <= state_d;
            step_count_q <= step_count_d;
        end
    end

    // With layer_count=0 the cost layer is also layer 0, so final_step exits COST straight to DONE.
    always_comb begin
        state_d      = state_q;
        step_count_d = step_count_q;
        if (load) begin
            step_count_d = '0;
        end else if (accept) begin
            step_count_d = step_count_q + 1'b1;
        end
        unique case (state_q)
            IDLE:  if (start) state_d = COST;
            COST: begin
                if (abort)                     state_d = IDLE;
                else if (step_ack && row_last) state_d = layer_zero ? DONE : DENSE;
            end
            DENSE: begin
                if (abort)                       state_d = IDLE;
                else if (step_ack && final_step) state_d = DONE;
            end
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        is_update     = active;
        busy          = active;
        backprop_cost = (state_q == COST);
        is_cost_layer = (state_q == COST);
        done          = (state_q == DONE);
        w_layer_index = active ? layer : '0;
        w_row_index   = active ? row : '0;
        step_count    = step_count_q;
    end

endmodule
